cic_decimator: RTL and testbench

Parametrised CIC (sinc^N) decimation filter for the 1-bit delta-sigma modulator bitstream. It generalises the fixed second-order, M=16 decimator to ORDER integrator/comb stages and a runtime power-of-two ratio. It supports a one-shot incremental conversion mode and a free-running mode, and adds a valid/busy handshake. It sits between the ADC bit input pin and the 16-bit output pins in the top level.

---
 rtl/cic_pkg.sv | 25 ++
 rtl/cic_decimator_if.sv | 26 ++
 rtl/cic_comb_chain.sv | 32 +++
 rtl/cic_decimator.sv | 133 +++++++++++++
 tb/tb_cic_decimator.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cic_pkg.sv
// Shared types and helpers for the CIC decimator.
package cic_pkg;

   localparam int unsigned ORDER_MAX = 4;

   typedef enum logic [1:0] {
      StIdle,
      StConv,
      StStream
   } cic_state_e;

   function automatic int unsigned cic_out_w(input int unsigned order,
                                             input int unsigned max_r_log2);
      return order * max_r_log2 + 1;
   endfunction

   // A ratio of 2^0 is promoted to 2^1; anything above the maximum is clamped.
   function automatic int unsigned clamp_r_log2(input int unsigned r_log2,
                                                input int unsigned max_r_log2);
      if (r_log2 == 0) return 1;
      if (r_log2 > max_r_log2) return max_r_log2;
      return r_log2;
   endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample input, configuration and result/handshake bundle for cic_decimator.
interface cic_decimator_if #(
   parameter int unsigned MAX_R_LOG2 = 8,
   parameter int unsigned OUT_W      = 17
);
   localparam int unsigned RLW = $clog2(MAX_R_LOG2 + 1);

   logic             in_valid;
   logic             x;
   logic             mode;
   logic [RLW-1:0]   r_log2;
   logic             start;
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             busy;

   modport master (
      output in_valid, x, mode, r_log2, start,
      input  out_data, out_valid, busy
   );

   modport slave (
      input  in_valid, x, mode, r_log2, start,
      output out_data, out_valid, busy
   );
endinterface

// File: rtl/cic_comb_chain.sv
// Comb (differentiator) chain with unit differential delay; the difference is combinational.
module cic_comb_chain #(
   parameter int unsigned ORDER = 2,
   parameter int unsigned OUT_W = 17
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [OUT_W-1:0] din_i,
   output logic [OUT_W-1:0] dout_o
);
   logic [OUT_W-1:0] dly_q [ORDER];
   logic [OUT_W-1:0] stage_in [ORDER];

   always_comb begin
      logic [OUT_W-1:0] acc;
      acc = din_i;
      for (int k = 0; k < ORDER; k++) begin
         stage_in[k] = acc;
         acc         = acc - dly_q[k];
      end
      dout_o = acc;
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int k = 0; k < ORDER; k++) dly_q[k] <= '0;
      end else if (en_i) begin
         for (int k = 0; k < ORDER; k++) dly_q[k] <= stage_in[k];
      end
   end
endmodule

// File: rtl/cic_decimator.sv
// sinc^ORDER decimator for a 1-bit modulator stream, one-shot or free-running.
// Optional CIC_NORM_EN scales the result so full scale is independent of r_log2.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int unsigned ORDER      = 2,
   parameter int unsigned MAX_R_LOG2 = 8,
   parameter int unsigned OUT_W      = cic_out_w(ORDER, MAX_R_LOG2)
) (
   input logic           clk,
   input logic           reset,
   cic_decimator_if.slave bus_io
);
   localparam int unsigned RLW    = $clog2(MAX_R_LOG2 + 1);
   localparam int unsigned CW     = MAX_R_LOG2;
   localparam int unsigned WARM_W = $clog2(ORDER_MAX);
   localparam logic [WARM_W-1:0] WARM_N = WARM_W'(ORDER - 1);

   cic_state_e        state_q;
   logic              mode_q;
   logic [RLW-1:0]    rlog_q;
   logic [OUT_W-1:0]  integ_q [ORDER];
   logic [OUT_W-1:0]  integ_d [ORDER];
   logic [CW-1:0]     cnt_q;
   logic [WARM_W-1:0] warm_q;
   logic [OUT_W-1:0]  out_data_q;
   logic              out_valid_q;

   int unsigned       rl_eff;
   logic [CW-1:0]     cnt_last;
   logic              accept, dec_evt, cfg_chg;
   logic              comb_clr, comb_en;
   logic [OUT_W-1:0]  comb_out, raw_res, res;

   always_comb begin
      logic [OUT_W-1:0] acc;
      rl_eff   = clamp_r_log2(32'(rlog_q), MAX_R_LOG2);
      cnt_last = {CW{1'b1}} >> (CW - rl_eff);
      accept   = bus_io.in_valid && (state_q != StIdle);
      dec_evt  = accept && (cnt_q == cnt_last);
      cfg_chg  = (bus_io.mode != mode_q) || (bus_io.r_log2 != rlog_q);
      acc      = integ_q[0] + OUT_W'(bus_io.x);
      integ_d[0] = acc;
      for (int k = 1; k < ORDER; k++) begin
         acc        = integ_q[k] + acc;
         integ_d[k] = acc;
      end
      comb_clr = reset || cfg_chg || (state_q == StIdle && mode_q);
      comb_en  = dec_evt && (state_q == StStream);
      raw_res  = (state_q == StConv) ? integ_d[ORDER-1] : comb_out;
`ifdef CIC_NORM_EN
      res = raw_res << (ORDER * (MAX_R_LOG2 - rl_eff));
`else
      res = raw_res;
`endif
   end

   cic_comb_chain #(
      .ORDER (ORDER),
      .OUT_W (OUT_W)
   ) u_comb (
      .clk_i  (clk),
      .clr_i  (comb_clr),
      .en_i   (comb_en),
      .din_i  (integ_d[ORDER-1]),
      .dout_o (comb_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         mode_q      <= bus_io.mode;
         rlog_q      <= bus_io.r_log2;
         for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
         cnt_q       <= '0;
         warm_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else if (cfg_chg) begin
         // Re-configure from a clean slate; out_data keeps its last result.
         mode_q      <= bus_io.mode;
         rlog_q      <= bus_io.r_log2;
         for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
         cnt_q       <= '0;
         warm_q      <= '0;
         out_valid_q <= 1'b0;
         state_q     <= bus_io.mode ? StStream : StIdle;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (mode_q || bus_io.start) begin
                  for (int k = 0; k < ORDER; k++) integ_q[k] <= '0;
                  cnt_q   <= '0;
                  warm_q  <= '0;
                  state_q <= mode_q ? StStream : StConv;
               end
            end
            StConv: begin
               if (accept) begin
                  for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
                  cnt_q <= dec_evt ? '0 : cnt_q + CW'(1);
               end
               if (dec_evt) begin
                  out_data_q  <= res;
                  out_valid_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            StStream: begin
               if (accept) begin
                  for (int k = 0; k < ORDER; k++) integ_q[k] <= integ_d[k];
                  cnt_q <= dec_evt ? '0 : cnt_q + CW'(1);
               end
               // The first ORDER-1 comb outputs still see the cleared delays.
               if (dec_evt) begin
                  if (warm_q == WARM_N) begin
                     out_data_q  <= res;
                     out_valid_q <= 1'b1;
                  end else begin
                     warm_q <= warm_q + WARM_W'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.out_data  = out_data_q;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_cic_decimator.sv
// Scoreboard bench for cic_decimator (ORDER=2, MAX_R_LOG2=8); honours CIC_NORM_EN.
module tb_cic_decimator;
   localparam int unsigned ORDER      = 2;
   localparam int unsigned MAX_R_LOG2 = 8;
   localparam int unsigned OUT_W      = ORDER * MAX_R_LOG2 + 1;
`ifdef CIC_NORM_EN
   localparam bit NORM = 1'b1;
`else
   localparam bit NORM = 1'b0;
`endif

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q[$];

   cic_decimator_if #(.MAX_R_LOG2(MAX_R_LOG2), .OUT_W(OUT_W)) bus ();

   cic_decimator #(
      .ORDER      (ORDER),
      .MAX_R_LOG2 (MAX_R_LOG2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .bus_io (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int exp_val(input int raw, input int rl);
      return NORM ? (raw << (ORDER * (MAX_R_LOG2 - rl))) : raw;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input bit xv, input bit push, input int val);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.x        = xv;
      if (push) begin
         e.val = val;
         e.cyc = cyc + 1;
         q.push_back(e);
      end
      tick();
   endtask

   task automatic restart_stream();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Monitor: every strobe must match the oldest expectation in value and cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            n_tests++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_strobe: out_data=%0d at cycle %0d, expected no strobe",
                        bus.out_data, cyc);
            end else begin
               e = q.pop_front();
               if (int'(bus.out_data) != e.val || cyc != e.cyc) begin
                  n_fail++;
                  $display("FAIL strobe: got %0d at cycle %0d, expected %0d at cycle %0d",
                           bus.out_data, cyc, e.val, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.x        = 1'b0;
      bus.mode     = 1'b0;
      bus.r_log2   = 4'd4;
      bus.start    = 1'b0;
      tick();
      tick();
      check("reset_out_data", int'(bus.out_data), 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_busy", int'(bus.busy), 0);
      reset = 1'b0;
      tick();

      // Incremental conversion: 16 ones -> 136, then idle with no further strobes.
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("conv_busy", int'(bus.busy), 1);
      for (int i = 1; i <= 16; i++) sample(1'b1, i == 16, exp_val(136, 4));
      check("conv_done_busy", int'(bus.busy), 0);
      for (int i = 1; i <= 16; i++) sample(1'b1, 1'b0, 0);
      bus.in_valid = 1'b0;
      tick();

      // Free-running, all ones: warm-up event suppressed, then 256 every 16 samples.
      bus.mode = 1'b1;
      tick();
      check("stream_busy", int'(bus.busy), 1);
      for (int i = 1; i <= 64; i++) sample(1'b1, i >= 32 && i % 16 == 0, exp_val(256, 4));

      // Alternating 1010 -> half scale.
      restart_stream();
      for (int i = 1; i <= 64; i++) begin
         sample(i % 2 == 1, i >= 32 && i % 16 == 0, exp_val(128, 4));
      end

      // in_valid gaps: same values, strobes spread out.
      restart_stream();
      for (int i = 1; i <= 64; i++) begin
         sample(1'b1, i >= 32 && i % 16 == 0, exp_val(256, 4));
         bus.in_valid = 1'b0;
         tick();
      end

      // Ratio change mid-frame: no strobe that cycle, out_data holds, new warm-up.
      restart_stream();
      for (int i = 1; i <= 40; i++) sample(1'b1, i == 32, exp_val(256, 4));
      bus.r_log2 = 4'd3;
      sample(1'b1, 1'b0, 0);
      check("cfg_out_hold", int'(bus.out_data), exp_val(256, 4));
      check("cfg_busy", int'(bus.busy), 1);
      for (int i = 1; i <= 32; i++) sample(1'b1, i >= 16 && i % 8 == 0, exp_val(64, 3));

      // Reset in the middle of a conversion; a start during reset is ignored.
      bus.mode     = 1'b0;
      bus.r_log2   = 4'd4;
      bus.in_valid = 1'b0;
      tick();
      check("idle_after_mode0", int'(bus.busy), 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 1; i <= 5; i++) sample(1'b1, 1'b0, 0);
      bus.in_valid = 1'b0;
      reset        = 1'b1;
      bus.start    = 1'b1;
      tick();
      check("midconv_reset_out_data", int'(bus.out_data), 0);
      check("midconv_reset_out_valid", int'(bus.out_valid), 0);
      check("midconv_reset_busy", int'(bus.busy), 0);
      reset     = 1'b0;
      bus.start = 1'b0;
      tick();
      check("start_in_reset_ignored", int'(bus.busy), 0);
      repeat (4) tick();

      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end
endmodule
